// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared slot type, sizing constants and source-match helper for the scoreboard
package definitions;

  localparam int SB_MAX_LATENCY = 8;
  localparam int SB_NUM_REGS    = 32;
  localparam int SB_RW          = $clog2(SB_NUM_REGS);
  localparam int SB_LW          = $clog2(SB_MAX_LATENCY + 1);

  // One reservation: a pending write of rd, issued with latency lat.
  typedef struct packed {
    logic             valid;
    logic [SB_RW-1:0] rd;
    logic [SB_LW-1:0] lat;
  } sb_slot_t;

  // A read source depends on a slot when it is used, nonzero and names the slot's rd.
  function automatic logic sb_src_match(sb_slot_t slot, logic [SB_RW-1:0] rs, logic uses);
    return uses && (rs != '0) && slot.valid && (slot.rd == rs);
  endfunction

endpackage

// File: rtl/scoreboard.sv
// rtl/scoreboard.sv - latency-indexed reservation scoreboard: issue stall, forwarding selects, writeback stream
module scoreboard
  import definitions::*;
#(
  parameter int NUM_REGS    = SB_NUM_REGS,
  parameter int MAX_LATENCY = SB_MAX_LATENCY,
  parameter int FLUSH_DEPTH = 2,
  localparam int RW = $clog2(NUM_REGS),
  localparam int LW = $clog2(MAX_LATENCY + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          issue_valid_i,
  input  logic [RW-1:0] issue_rd_i,
  input  logic          issue_we_i,
  input  logic [RW-1:0] issue_rs1_i,
  input  logic [RW-1:0] issue_rs2_i,
  input  logic          issue_uses_rs1_i,
  input  logic          issue_uses_rs2_i,
  input  logic [LW-1:0] issue_latency_i,
  input  logic          stall_pipe_i,
  input  logic          flush_i,
  output logic          stall_o,
  output logic          issue_fire_o,
  output logic          rs1_fwd_o,
  output logic          rs2_fwd_o,
  output logic          wb_valid_o,
  output logic [RW-1:0] wb_rd_o,
  output logic          busy_o
);

  // Slot i holds the write that reaches the writeback port i advance cycles from now.
  sb_slot_t slots     [MAX_LATENCY];
  sb_slot_t slots_nxt [MAX_LATENCY];

  logic [MAX_LATENCY-1:0] rs1_hit, rs2_hit, waw_hit, port_hit, valid_vec;
  logic raw, waw, port;

  for (genvar g = 0; g < MAX_LATENCY; g++) begin : g_match
    assign rs1_hit[g]   = sb_src_match(slots[g], issue_rs1_i, issue_uses_rs1_i);
    assign rs2_hit[g]   = sb_src_match(slots[g], issue_rs2_i, issue_uses_rs2_i);
    // An older write landing at or after our own writeback slot would reorder rd.
    assign waw_hit[g]   = slots[g].valid && (slots[g].rd == issue_rd_i) && (g >= int'(issue_latency_i));
    // Our entry lands in slot L-1 after the shift, which is where slot L moves to.
    assign port_hit[g]  = slots[g].valid && (g == int'(issue_latency_i));
    assign valid_vec[g] = slots[g].valid;
  end

  // Slot 0 is excluded from raw: that value is on the writeback bus and can be forwarded.
  assign raw  = (|rs1_hit[MAX_LATENCY-1:1]) || (|rs2_hit[MAX_LATENCY-1:1]);
  assign waw  = issue_we_i && (issue_rd_i != '0) && (|waw_hit);
  assign port = issue_we_i && (|port_hit);

  assign stall_o      = issue_valid_i && (stall_pipe_i || raw || waw || port);
  assign issue_fire_o = issue_valid_i && !stall_o && !flush_i;
  assign rs1_fwd_o    = rs1_hit[0] && !raw;
  assign rs2_fwd_o    = rs2_hit[0] && !raw;

  assign wb_valid_o = slots[0].valid;
  assign wb_rd_o    = slots[0].rd;
  assign busy_o     = |valid_vec;

  // Next slot state: flush kills young entries, then advance, then insert the new reservation.
  always_comb begin
    for (int i = 0; i < MAX_LATENCY; i++) slots_nxt[i] = slots[i];
    if (flush_i) begin
      for (int i = 0; i < MAX_LATENCY; i++) begin
        if (slots[i].valid && (int'(slots[i].lat) - 1 - i < FLUSH_DEPTH)) slots_nxt[i] = '0;
      end
    end
    if (!stall_pipe_i) begin
      for (int i = 0; i < MAX_LATENCY - 1; i++) slots_nxt[i] = slots_nxt[i+1];
      slots_nxt[MAX_LATENCY-1] = '0;
    end
    if (issue_fire_o && issue_we_i && (issue_rd_i != '0)) begin
      for (int i = 0; i < MAX_LATENCY; i++) begin
        if (int'(issue_latency_i) == i + 1) slots_nxt[i] = '{valid: 1'b1, rd: issue_rd_i, lat: issue_latency_i};
      end
    end
  end

  // Slot register; reset discards every reservation without writing it back.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < MAX_LATENCY; i++) slots[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_LATENCY; i++) slots[i] <= slots_nxt[i];
    end
  end

  // Latency outside 1..MAX_LATENCY on a valid issue is a decode bug upstream.
  always_ff @(posedge clk_i) begin
    if (!reset_i && issue_valid_i) begin
      assert (int'(issue_latency_i) >= 1 && int'(issue_latency_i) <= MAX_LATENCY)
        else $error("scoreboard: illegal issue latency %0d", issue_latency_i);
    end
  end

endmodule

// File: doc/scoreboard.md
# scoreboard

Parametrised register scoreboard that replaces per-stage RAW checks against fixed functional-unit stages with a latency-indexed reservation shift register. Sits in the ID stage alongside decode. Tracks every in-flight register write from issue to writeback, plus the shared writeback port. Produces the issue stall, writeback-stage forwarding selects, and the writeback stream. Handles units of any latency up to `MAX_LATENCY` (ALU, multiplier, future divider), full-pipeline freezes, and control-hazard flushes.

## Interface
- `NUM_REGS`, 32: architectural registers; register 0 is hardwired zero.
- `MAX_LATENCY`, 8: largest issue latency accepted; also the number of reservation slots.
- `FLUSH_DEPTH`, 2: entries younger than this many advance cycles are killed by `flush_i`.
- Derived: `RW = $clog2(NUM_REGS)`, `LW = $clog2(MAX_LATENCY+1)`.

Ports:
- `clk_i` in 1: clock.
- `reset_i` in 1: synchronous, active-high reset.
- `issue_valid_i` in 1: ID holds a valid instruction.
- `issue_rd_i` in RW: destination register.
- `issue_we_i` in 1: instruction writes `rd`.
- `issue_rs1_i`, `issue_rs2_i` in RW: source registers.
- `issue_uses_rs1_i`, `issue_uses_rs2_i` in 1: source is read.
- `issue_latency_i` in LW: cycles from issue to writeback, range 1..`MAX_LATENCY`.
- `stall_pipe_i` in 1: full-pipeline freeze (cache miss, store buffer full).
- `flush_i` in 1: control hazard, kill young entries.
- `stall_o` out 1: issue blocked.
- `issue_fire_o` out 1: issue accepted this cycle.
- `rs1_fwd_o`, `rs2_fwd_o` out 1: take the source from the writeback bus.
- `wb_valid_o` out 1: writeback this cycle.
- `wb_rd_o` out RW: register being written back.
- `busy_o` out 1: any slot valid.

## Operation
**Slot state**
- Slots 0..`MAX_LATENCY`-1, each holding {valid, rd, lat}.
- Slot 0 is the writeback slot: `wb_valid_o = slot[0].valid`, `wb_rd_o = slot[0].rd`.

**Issue stall**
- `stall_o = issue_valid_i && (stall_pipe_i || raw || waw || port)`.
- raw: a used, nonzero rs matches the rd of a valid slot with index ≥ 1.
- waw: `issue_we_i`, rd≠0, and a valid slot with index ≥ L has the same rd. L is the issue latency.
- port: `issue_we_i`, L < `MAX_LATENCY`, and `slot[L].valid`.

**Fire and forwarding**
- `issue_fire_o = issue_valid_i && !stall_o && !flush_i`.
- `rsN_fwd_o` = 1 when a used rs≠0 matches `slot[0].rd` with slot 0 valid and raw is 0.

**Per clock edge** (not in reset), in this order:
1. If `flush_i`: kill every valid slot whose age < `FLUSH_DEPTH`, where age = lat−1−index.
2. If not `stall_pipe_i`: slot[i] ← slot[i+1]; the top slot becomes invalid; slot 0 retires.
3. If `issue_fire_o` and `issue_we_i` and rd≠0: write {1, rd, L} into slot L−1.

**Rules**
- The issue write never collides with a shifted entry; the port check guarantees this.
- `flush_i` together with `stall_pipe_i`: kill without shifting.
- `issue_latency_i` of 0 or greater than `MAX_LATENCY` is illegal; flag it with a simulation assertion.
- Register 0 is never reserved and never forwarded.

## Timing
- Issue fires at cycle t with latency L and no freezes: `wb_valid_o` is high exactly at cycle t+L, for one cycle.
- Each frozen cycle delays writeback by one cycle.
- `stall_o`, `issue_fire_o` and the forward selects are combinational from inputs and slot state. No registered outputs.
- Reset: all slots invalid.
- Reset values: `wb_valid_o`=0, `wb_rd_o`=0, `busy_o`=0, `rs*_fwd_o`=0. `stall_o` = `issue_valid_i && stall_pipe_i`.
- Reset asserted mid-operation discards all reservations on that edge; no writeback is emitted for them.
- Back-to-back issues are allowed every cycle when there are no conflicts. Example: L=1 followed by L=1 gives writebacks in consecutive cycles.

## Structure
- Package `definitions` gets:
  - typedef `sb_slot_t` (valid, rd, lat);
  - constant `SB_MAX_LATENCY`;
  - function `sb_src_match(slot, rs, uses)`.
- Single flat module. Match logic is a generate loop over slots; no sub-module.

## Test plan
1. Reset, then issue rd=5, L=1 at t0 → `issue_fire_o`=1; `wb_valid_o`=1 with `wb_rd_o`=5 at t0+1; `busy_o`=0 at t0+2.
2. Issue rd=7, L=6 at t0, then rs1=7 at t0+1 → `stall_o`=1 for cycles t0+1..t0+5. At t0+6, `rs1_fwd_o`=1, `stall_o`=0, fire.
3. Issue rd=3, L=4 at t0, then rd=4, L=3 at t0+1 → port conflict: stall at t0+1; fires at t0+2 with writeback at t0+5.
4. Issue rd=9, L=5 at t0, then rd=9, L=1 at t0+1 → WAW stall until t0+4. Writebacks occur at t0+5 and then t0+5 is followed by t0+5+1 in order.
5. rd=2, L=4 at t0; `stall_pipe_i` held for 3 cycles starting at t0+1 → writeback at t0+7; `stall_o`=1 throughout the freeze.
6. Issue rd=6, L=6 at t0, then rd=8, L=6 at t0+1; `flush_i` at t0+2 with `FLUSH_DEPTH`=1 → rd=8 is killed and never written back; rd=6 writes back at t0+6.
